alu_mc: RTL

Parametrised, registered successor to the 32-bit combinational ALU. Accepts one operation per valid/ready handshake and holds the result until the consumer takes it. Division is an iterative restoring divider instead of a combinational one. Sits between the operand/register-read stage and writeback, and is shared by any master using the 5-bit op encoding below.

---
 rtl/alu_mc.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle ops complete on the accept edge; divide runs an iterative restoring divider.
// Optional macro ALU_OVF_EN adds a registered signed-overflow output.
module alu_mc #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] mulhi,
    output logic             carry,
    output logic             zero,
    output logic             dz
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d, mulhi_q, mulhi_d;
    logic carry_q, carry_d, zero_q, zero_d, dz_q, dz_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [SHW-1:0] cnt_q, cnt_d;

    logic             in_ready_c, accept;
    logic [WIDTH:0]   add_w, inc_w;
    logic [WIDTH-1:0] sub_w, dec_w, nega_w, negb_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0] res_c, hi_c;
    logic             cy_c, dz_c;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    assign add_w  = {1'b0, a} + {1'b0, b};
    assign inc_w  = {1'b0, a} + (WIDTH+1)'(1);
    assign sub_w  = a - b;
    assign dec_w  = a - WIDTH'(1);
    assign nega_w = '0 - a;
    assign negb_w = '0 - b;
    assign prod_w = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        res_c = '0;
        hi_c  = '0;
        cy_c  = 1'b0;
        dz_c  = 1'b0;
        case (s)
            5'd0:  begin res_c = add_w[WIDTH-1:0]; cy_c = add_w[WIDTH]; end
            5'd1:  begin res_c = sub_w; cy_c = (a < b); end
            5'd2:  begin res_c = prod_w[WIDTH-1:0]; hi_c = prod_w[2*WIDTH-1:WIDTH]; end
            // Only the b==0 case reaches this result; nonzero divisors go to the FSM.
            5'd3:  begin res_c = '0; hi_c = a; dz_c = (b == '0); end
            5'd4:  res_c = ~a;
            5'd5:  res_c = a & b;
            5'd6:  res_c = ~(a & b);
            5'd7:  res_c = a | b;
            5'd8:  res_c = ~(a | b);
            5'd9:  res_c = gray2bin(b);
            5'd10: res_c = (a > b) ? '1 : '0;
            5'd11: res_c = nega_w;
            5'd12: res_c = negb_w;
            5'd13: res_c = ~a;
            5'd14: res_c = ~b;
            5'd15: res_c = (a == b) ? '1 : '0;
            5'd16: res_c = gray2bin(a);
            5'd17: res_c = b ^ (b >> 1);
            5'd18: res_c = a ^ (a >> 1);
            5'd19: res_c = a ^ b;
            5'd20: res_c = ~(a ^ b);
            5'd21: res_c = {{(WIDTH-1){1'b0}}, a[0] & b[0]};
            5'd22: res_c = {{(WIDTH-1){1'b0}}, a[0] | b[0]};
            5'd23: res_c = {{(WIDTH-1){1'b0}}, ~a[0]};
            5'd24: begin res_c = inc_w[WIDTH-1:0]; cy_c = inc_w[WIDTH]; end
            5'd25: begin res_c = dec_w; cy_c = (a == '0); end
            5'd26: res_c = a >> b[SHW-1:0];
            5'd27: res_c = '0;
            5'd28: res_c = bitrev(a);
            5'd29: res_c = {{(WIDTH-1){1'b0}}, ^a};
            5'd30: res_c = {{(WIDTH-1){1'b0}}, ^b};
            5'd31: res_c = a << b[SHW-1:0];
            default: res_c = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d, ov_c;

    always_comb begin
        ov_c = 1'b0;
        case (s)
            5'd0:  ov_c = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            5'd1:  ov_c = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            5'd11: ov_c = a[WIDTH-1] && nega_w[WIDTH-1];
            5'd12: ov_c = b[WIDTH-1] && negb_w[WIDTH-1];
            5'd24: ov_c = !a[WIDTH-1] && inc_w[WIDTH-1];
            5'd25: ov_c = a[WIDTH-1] && !dec_w[WIDTH-1];
            default: ov_c = 1'b0;
        endcase
    end

    assign ovf = ovf_q;
`endif

    // One restoring step: rem < dvs always holds, so the shifted value fits WIDTH+1 bits
    // and the difference fits back into WIDTH bits.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    always_comb begin
        rem_nx = rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_nx = rem_sh[WIDTH-1:0] - dvs_q;
            quo_nx[0] = 1'b1;
        end
    end

    assign in_ready_c = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
    assign accept     = in_valid && in_ready_c;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        mulhi_d     = mulhi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
`ifdef ALU_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
                if (accept) begin
                    if (s == 5'd3 && b != '0) begin
                        state_d     = DIV;
                        rem_d       = '0;
                        quo_d       = a;
                        dvs_d       = b;
                        cnt_d       = SHW'(WIDTH - 1);
                        out_valid_d = 1'b0;
                    end else begin
                        out_d       = res_c;
                        mulhi_d     = hi_c;
                        carry_d     = cy_c;
                        dz_d        = dz_c;
                        zero_d      = (res_c == '0);
                        out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
                        ovf_d       = ov_c;
`endif
                    end
                end
            end
            DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_d       = quo_nx;
                    mulhi_d     = rem_nx;
                    carry_d     = 1'b0;
                    dz_d        = 1'b0;
                    zero_d      = (quo_nx == '0);
                    out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
                    ovf_d       = 1'b0;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            mulhi_q     <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
`ifdef ALU_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            mulhi_q     <= mulhi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
`ifdef ALU_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign mulhi     = mulhi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign dz        = dz_q;

endmodule
